// File: rtl/train_sensor_emulator.sv
// Emits S1..S6 pulses that imitate a train passing six track sensors, either direction.
// Define BOUNCE_EN to model contact bounce (1,0,1,1...) on each pulse.
module train_sensor_emulator #(
    parameter int CNT_W        = 19,
    parameter int PULSE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic             loop_en,
    input  logic [CNT_W-1:0] seg_time,
    output logic             S1,
    output logic             S2,
    output logic             S3,
    output logic             S4,
    output logic             S5,
    output logic             S6,
    output logic [2:0]       sensor_idx,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0]       PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             dir_q, dir_d;
    logic [5:0]       s_q, s_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             level;

    // Handshake: start is a one-cycle request honoured only in IDLE with abort low;
    // abort is level-sampled every cycle and overrides everything except reset.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        dir_d   = dir_q;

        case (state_q)
            IDLE: begin
                idx_d = 3'd0;
                if (start && !abort) begin
                    dir_d   = dir;
                    gap_d   = (seg_time == '0) ? GAP_ONE : seg_time;
                    idx_d   = dir ? 3'd5 : 3'd0;
                    pcnt_d  = 8'd0;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (pcnt_q == PULSE_LAST) begin
                    pcnt_d = 8'd0;
                    if (idx_q == (dir_q ? 3'd0 : 3'd5)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = gap_q;
                        state_d = GAP;
                    end
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_ONE) begin
                    idx_d   = dir_q ? (idx_q - 3'd1) : (idx_q + 3'd1);
                    pcnt_d  = 8'd0;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q - GAP_ONE;
                end
            end
            DONE: begin
                if (loop_en) begin
                    idx_d   = dir_q ? 3'd5 : 3'd0;
                    pcnt_d  = 8'd0;
                    state_d = PULSE;
                end else begin
                    idx_d   = 3'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            pcnt_d  = 8'd0;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from next-state so the first pulse appears one cycle after start.
`ifdef BOUNCE_EN
    assign level = (pcnt_d != 8'd1);
`else
    assign level = 1'b1;
`endif

    always_comb begin
        s_d = 6'b0;
        if (state_d == PULSE) begin
            for (int i = 0; i < 6; i++) begin
                if (idx_d == 3'(i)) begin
                    s_d[i] = level;
                end
            end
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            pcnt_q  <= 8'd0;
            cnt_q   <= '0;
            gap_q   <= '0;
            dir_q   <= 1'b0;
            s_q     <= 6'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            dir_q   <= dir_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign S1          = s_q[0];
    assign S2          = s_q[1];
    assign S3          = s_q[2];
    assign S4          = s_q[3];
    assign S5          = s_q[4];
    assign S6          = s_q[5];
    assign sensor_idx  = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_train_sensor_emulator.sv
// Scoreboard bench for train_sensor_emulator: expected output words queued per cycle, checked by a monitor.
module tb_train_sensor_emulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        dir;
  logic        loop_en;
  logic [18:0] seg_time;
  logic        s1, s2, s3, s4, s5, s6;
  logic [2:0]  sensor_idx;
  logic        busy;
  logic        done;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  train_sensor_emulator #(
    .CNT_W(19),
    .PULSE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .dir(dir),
    .loop_en(loop_en),
    .seg_time(seg_time),
    .S1(s1),
    .S2(s2),
    .S3(s3),
    .S4(s4),
    .S5(s5),
    .S6(s6),
    .sensor_idx(sensor_idx),
    .busy(busy),
    .done(done),
    .fsm_state_o(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: {busy, done, sensor_idx[2:0], S6..S1}.
  // t = cycle number counted from the start cycle (t=1 is the first pulse cycle).
  // Pulse 4 cycles, gap g: sensor k high over t = 1+k*(4+g) .. 4+k*(4+g); done at 24+5g+1.
  function automatic logic [10:0] pass_word(input int t, input int g, input bit rev);
    int per, k, r, idx, tdone;
    logic [5:0] s;
    logic lvl;
    per = 4 + g;
    tdone = 24 + 5 * g + 1;
    s = 6'b0;
    if (t < 1 || t > tdone) return 11'd0;
    if (t == tdone) return {1'b1, 1'b1, (rev ? 3'd0 : 3'd5), 6'b0};
    k = (t - 1) / per;
    r = (t - 1) % per;
    idx = rev ? 5 - k : k;
    if (r < 4) begin
      lvl = 1'b1;
`ifdef BOUNCE_EN
      if (r == 1) lvl = 1'b0;
`endif
      s[idx] = lvl;
    end
    return {1'b1, 1'b0, 3'(idx), s};
  endfunction

  // driver: inputs held for one cycle; expected word is for the output after that edge
  task automatic cyc(input logic st, input logic ab, input logic rs, input logic dr,
                     input logic le, input logic [18:0] seg, input logic [10:0] exp_w);
    start = st;
    abort = ab;
    rst = rs;
    dir = dr;
    loop_en = le;
    seg_time = seg;
    @(posedge clk);
    exp_q.push_back(exp_w);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [10:0] act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {busy, done, sensor_idx, s6, s5, s4, s3, s2, s1};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL out_word t=%0t actual=%b expected=%b", $time, act, e);
      end
      checks++;
      if ($countones({s6, s5, s4, s3, s2, s1}) > 1) begin
        errors++;
        $display("FAIL one_hot t=%0t actual=%b expected=at most one high", $time,
                 {s6, s5, s4, s3, s2, s1});
      end
    end
  end

  initial begin
    start = 0; abort = 0; rst = 1; dir = 0; loop_en = 0; seg_time = '0;

    // reset: outputs zero even with start requested
    cyc(1, 0, 1, 0, 0, 19'd10, 11'd0);
    cyc(0, 0, 1, 0, 0, 19'd10, 11'd0);
    cyc(0, 0, 1, 0, 0, 19'd10, 11'd0);
    // start together with abort in IDLE: abort wins, nothing happens
    cyc(1, 1, 0, 0, 0, 19'd10, 11'd0);
    cyc(0, 0, 0, 0, 0, 19'd10, 11'd0);

    // forward, gap 10; dir/seg_time wiggled mid-pass must not matter
    for (int c = 0; c <= 80; c++)
      cyc(c == 0, 0, 0, (c == 0) ? 1'b0 : 1'b1, 0, (c == 0) ? 19'd10 : 19'd3,
          pass_word(c + 1, 10, 0));

    // reverse, gap 10
    for (int c = 0; c <= 80; c++)
      cyc(c == 0, 0, 0, (c == 0) ? 1'b1 : 1'b0, 0, (c == 0) ? 19'd10 : 19'd0,
          pass_word(c + 1, 10, 1));

    // seg_time = 0 behaves as a 1-cycle gap: done at 30
    for (int c = 0; c <= 34; c++)
      cyc(c == 0, 0, 0, 0, 0, 19'd0, pass_word(c + 1, 1, 0));

    // abort inside a gap at cycle 8, restart at cycle 12
    for (int c = 0; c <= 90; c++) begin
      int t;
      logic [10:0] w;
      t = c + 1;
      if (t <= 8) w = pass_word(t, 10, 0);
      else if (t <= 12) w = 11'd0;
      else w = pass_word(t - 12, 10, 0);
      cyc((c == 0) || (c == 12), c == 8, 0, 0, 0, 19'd10, w);
    end

    // loop mode: done at 75 then S1 again at 76; starts at 20/50 ignored; abort at 90
    for (int c = 0; c <= 95; c++) begin
      int t;
      logic [10:0] w;
      t = c + 1;
      if (t >= 91) w = 11'd0;
      else if (t <= 75) w = pass_word(t, 10, 0);
      else w = pass_word(t - 75, 10, 0);
      cyc((c == 0) || (c == 20) || (c == 50), c == 90, 0, 0, c < 90, 19'd10, w);
    end

    // reset mid-pass at cycle 16 (S2 high): zero from 17, stays idle
    for (int c = 0; c <= 24; c++)
      cyc(c == 0, 0, c == 16, 0, 0, 19'd10, (c + 1 <= 16) ? pass_word(c + 1, 10, 0) : 11'd0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d entries left expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
